// File: rtl/booth_div_32.sv
// rtl/booth_div_32.sv - sequential signed restoring divider, one quotient bit per clock
// Optional DIV_UNSIGNED_SEL_EN adds an is_signed input selecting unsigned operation.
module booth_div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_SEL_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH:0]   p_r;
  logic [CW-1:0]    cnt;
  logic             sq;
  logic             sr;
  logic             sgn_r;

`ifndef DIV_UNSIGNED_SEL_EN
  assign sgn_r = 1'b1;
`endif

  // Magnitudes in WIDTH+1 bits so that |-2^(WIDTH-1)| is representable.
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH:0]   dvd_x;
  logic [WIDTH:0]   dvs_x;
  logic [WIDTH:0]   dvd_mag;
  logic [WIDTH:0]   dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    dvd_neg = sgn_r & dvd_r[WIDTH-1];
    dvs_neg = sgn_r & dvs_r[WIDTH-1];
    dvd_x   = {dvd_neg, dvd_r};
    dvs_x   = {dvs_neg, dvs_r};
    dvd_mag = dvd_neg ? -dvd_x : dvd_x;
    dvs_mag = dvs_neg ? -dvs_x : dvs_x;
    shifted = {p_r[WIDTH-1:0], q_r[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, m_r};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      q_r         <= '0;
      m_r         <= '0;
      p_r         <= '0;
      cnt         <= '0;
      sq          <= 1'b0;
      sr          <= 1'b0;
`ifdef DIV_UNSIGNED_SEL_EN
      sgn_r       <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // done can still be high here after a divide-by-zero; that start is ignored.
          done <= 1'b0;
          if (done) begin
            busy <= 1'b0;
          end else if (start) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            busy  <= 1'b1;
`ifdef DIV_UNSIGNED_SEL_EN
            sgn_r <= is_signed;
`endif
            state <= (divisor == '0) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          q_r   <= dvd_mag[WIDTH-1:0];
          m_r   <= dvs_mag[WIDTH-1:0];
          p_r   <= '0;
          cnt   <= CW'(WIDTH);
          sq    <= dvd_neg ^ dvs_neg;
          sr    <= dvd_neg;
          state <= S_RUN;
        end
        S_RUN: begin
          if (!diff[WIDTH+1]) begin
            p_r <= diff[WIDTH:0];
            q_r <= {q_r[WIDTH-2:0], 1'b1};
          end else begin
            p_r <= shifted;
            q_r <= {q_r[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          quotient    <= sq ? -q_r : q_r;
          remainder   <= sr ? -p_r[WIDTH-1:0] : p_r[WIDTH-1:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          // Entered with done low only on the divide-by-zero shortcut.
          if (!done) begin
            quotient    <= '1;
            remainder   <= dvd_r;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end else begin
            done <= 1'b0;
            busy <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_div_32.sv
// tb/tb_booth_div_32.sv - self-checking bench for booth_div_32 against an arithmetic model
// Exercises the unsigned-select path when DIV_UNSIGNED_SEL_EN is defined.
module tb_booth_div_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_div_32 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIV_UNSIGNED_SEL_EN
    .is_signed  (is_signed),
`endif
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Round-toward-zero reference in 64-bit arithmetic.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end
  endtask

  task automatic wait_done(inout int cnt);
    while (!done && cnt < 80) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit sgn, input int lat);
    logic [31:0] eq, er;
    logic        ez;
    int          cnt;
    model(a, b, sgn, eq, er, ez);
    @(negedge clk);
    while (done) @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = sgn;
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    if (lat > 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(cnt);
    if (lat > 0) chk({tag, "_lat"}, cnt, lat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_z"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    int          cnt;
    bit          seen;
    logic [31:0] a, b;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_z", 32'(div_by_zero), 32'd0);

    run_op("t1", 32'd100, 32'd7, 1'b1, 35);
    run_op("t2a", -32'sd100, 32'd7, 1'b1, 35);
    run_op("t2b", 32'd100, -32'sd7, 1'b1, 35);
    run_op("t3a", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 35);
    run_op("t3b", 32'h8000_0000, 32'd1, 1'b1, 35);
    run_op("t3c", -32'sd7, -32'sd2, 1'b1, 35);
    run_op("t4", 32'd12345, 32'd0, 1'b1, 2);
    run_op("t4n", -32'sd5, 32'd0, 1'b1, 2);

    // Start during busy is ignored.
    @(negedge clk);
    while (done) @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) begin @(posedge clk); cnt++; end
    @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd9;
    @(posedge clk);
    cnt++;
    @(negedge clk);
    start = 1'b0;
    wait_done(cnt);
    chk("t5_lat", cnt, 35);
    chk("t5_q", quotient, 32'd333);
    chk("t5_r", remainder, 32'd1);

    // Start held through the done cycle is accepted one cycle later.
    start = 1'b1; dividend = 32'd77; divisor = 32'd7;
    @(posedge clk);
    @(negedge clk);
    chk("sd_busy", 32'(busy), 32'd0);
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cnt);
    chk("sd_lat", cnt, 35);
    chk("sd_q", quotient, 32'd11);

    // Reset mid-operation discards the result.
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mr_q", quotient, 32'd0);
    chk("mr_r", remainder, 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("mr_nodone", 32'(seen), 32'd0);
    run_op("mr_next", 32'd50, 32'd5, 1'b1, 35);

`ifdef DIV_UNSIGNED_SEL_EN
    run_op("t6", 32'hFFFF_FFFF, 32'd2, 1'b0, 35);
    run_op("t6z", 32'hFFFF_FFF0, 32'd0, 1'b0, 2);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (b == 32'd0) b = 32'd3;
      run_op("rnd_u", a, b, 1'b0, 35);
    end
`endif

    for (int i = 0; i < 160; i++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 1000));
        default: b = -32'($urandom_range(1, 1000));
      endcase
      if (($urandom_range(0, 3)) == 0) a = 32'($urandom_range(0, 5000));
      if (b == 32'd0) b = 32'd1;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
      run_op("rnd_s", a, b, 1'b1, 35);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
